// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction-class encodings and fetch state encodings.
package cpu_pkg;
    localparam int INSTR_WIDTH = 20;
    localparam int PC_BITS     = 5;
    localparam int CLS_MSB     = 19;
    localparam int CLS_LSB     = 18;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_FETCH = 5'b00010,
        S_WAIT  = 5'b00100,
        S_HOLD  = 5'b01000,
        S_HALT  = 5'b10000
    } fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with synchronous active-low reset; load beats increment.
module pc_reg
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_i,
    input  logic               inc_i,
    input  logic [PC_BITS-1:0] ld_addr_i,
    output logic [PC_BITS-1:0] pc_o
);
    localparam logic [PC_BITS-1:0] PC_ONE = 1;
    logic [PC_BITS-1:0] pc_q, pc_d;

    always_comb pc_d = ld_i ? ld_addr_i : inc_i ? pc_q + PC_ONE : pc_q;

    always_ff @(posedge clk)
        if (!rst) pc_q <= '0;
        else      pc_q <= pc_d;

    assign pc_o = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM reading a one-cycle-latency instruction memory and
// holding each word for the control unit until it advances or redirects.
module instr_fetch
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic [PC_BITS-1:0]     imem_addr,
    output logic                   imem_rd,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   next,
    input  logic                   jump_en,
    input  logic [PC_BITS-1:0]     jump_addr,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    output logic [PC_BITS-1:0]     pc,
    output logic                   halted
);
    fetch_state_e           state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   pc_ld, pc_inc;

    pc_reg u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .ld_i      (pc_ld),
        .inc_i     (pc_inc),
        .ld_addr_i (jump_addr),
        .pc_o      (pc)
    );

    always_comb begin
        state_d  = S_IDLE;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // A class-00 word halts the stage instead of being presented.
                if (imem_data[CLS_MSB:CLS_LSB] != CLS_HALT) begin
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    instr_d  = '0;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end
            end
            S_HOLD: begin
                state_d = S_HOLD;
                if (jump_en || next) begin
                    pc_ld   = jump_en;
                    pc_inc  = next;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
                if (jump_en) begin
                    pc_ld    = 1'b1;
                    halted_d = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst) begin
            state_q  <= S_IDLE;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end

    assign imem_rd     = (state_q == S_FETCH);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of the fetch stage against a registered memory model.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [PC_BITS-1:0]     imem_addr;
    logic                   imem_rd;
    logic [INSTR_WIDTH-1:0] imem_data = '0;
    logic                   next;
    logic                   jump_en;
    logic [PC_BITS-1:0]     jump_addr;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   halted;

    logic [INSTR_WIDTH-1:0] mem [32];
    int errors = 0;
    int checks = 0;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .next        (next),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_rd) imem_data <= mem[imem_addr];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0]  = 20'h4_1230;
        mem[1]  = 20'h8_0450;
        mem[2]  = 20'hC_0460;
        mem[3]  = 20'h0_0FFF;
        mem[20] = 20'h5_0001;
        mem[31] = 20'h4_0000;
        rst = 1'b0; next = 1'b0; jump_en = 1'b0; jump_addr = '0;
        step(); step();
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_rd", 32'(imem_rd), 32'h0);

        // first fetch
        rst = 1'b1;
        step();
        chk("t1_rd", 32'(imem_rd), 32'h1);
        chk("t1_addr", 32'(imem_addr), 32'h0);
        step();
        chk("t1_wait_rd", 32'(imem_rd), 32'h0);
        chk("t1_wait_valid", 32'(instr_valid), 32'h0);
        chk("t1_wait_instr", 32'(instr), 32'h0);
        step();
        chk("t1_instr", 32'(instr), 32'h41230);
        chk("t1_valid", 32'(instr_valid), 32'h1);
        chk("t1_pc", 32'(pc), 32'h0);
        step();
        chk("t1_hold_valid", 32'(instr_valid), 32'h1);
        chk("t1_hold_rd", 32'(imem_rd), 32'h0);

        // sequential advance
        next = 1'b1;
        step();
        next = 1'b0;
        chk("t2_rd", 32'(imem_rd), 32'h1);
        chk("t2_addr", 32'(imem_addr), 32'h1);
        chk("t2_instr_fetch", 32'(instr), 32'h41230);
        chk("t2_valid_fetch", 32'(instr_valid), 32'h0);
        step();
        chk("t2_instr_wait", 32'(instr), 32'h41230);
        chk("t2_rd_wait", 32'(imem_rd), 32'h0);
        step();
        chk("t2_instr", 32'(instr), 32'h80450);
        chk("t2_valid", 32'(instr_valid), 32'h1);

        // jump beats next
        next = 1'b1; jump_en = 1'b1; jump_addr = 5'd20;
        step();
        next = 1'b0; jump_en = 1'b0;
        chk("t3_pc", 32'(pc), 32'd20);
        chk("t3_addr", 32'(imem_addr), 32'd20);
        step(); step();
        chk("t3_instr", 32'(instr), 32'h50001);
        chk("t3_pc_hold", 32'(pc), 32'd20);

        // wrap-around
        jump_en = 1'b1; jump_addr = 5'd31;
        step();
        jump_en = 1'b0;
        step(); step();
        chk("t4_instr31", 32'(instr), 32'h40000);
        chk("t4_pc31", 32'(pc), 32'd31);
        next = 1'b1;
        step();
        next = 1'b0;
        chk("t4_pc", 32'(pc), 32'h0);
        chk("t4_addr", 32'(imem_addr), 32'h0);
        chk("t4_rd", 32'(imem_rd), 32'h1);
        step(); step();
        chk("t4_instr", 32'(instr), 32'h41230);

        // halt at word 3
        for (int k = 0; k < 3; k++) begin
            next = 1'b1;
            step();
            next = 1'b0;
            step(); step();
        end
        chk("t5_halted", 32'(halted), 32'h1);
        chk("t5_instr", 32'(instr), 32'h0);
        chk("t5_valid", 32'(instr_valid), 32'h0);
        chk("t5_pc", 32'(pc), 32'd3);
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        chk("t5_next_halted", 32'(halted), 32'h1);
        chk("t5_next_pc", 32'(pc), 32'd3);
        chk("t5_next_rd", 32'(imem_rd), 32'h0);
        jump_en = 1'b1; jump_addr = 5'd0;
        step();
        jump_en = 1'b0;
        chk("t5_jmp_halted", 32'(halted), 32'h0);
        chk("t5_jmp_pc", 32'(pc), 32'h0);
        chk("t5_jmp_rd", 32'(imem_rd), 32'h1);
        step(); step();
        chk("t5_instr0", 32'(instr), 32'h41230);
        chk("t5_valid0", 32'(instr_valid), 32'h1);

        // reset during WAIT
        next = 1'b1;
        step();
        next = 1'b0;
        step();
        chk("t6_in_wait_pc", 32'(pc), 32'h1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_pc", 32'(pc), 32'h0);
        chk("t6_instr", 32'(instr), 32'h0);
        chk("t6_valid", 32'(instr_valid), 32'h0);
        chk("t6_halted", 32'(halted), 32'h0);
        chk("t6_rd_idle", 32'(imem_rd), 32'h0);
        step();
        chk("t6_rd_fetch", 32'(imem_rd), 32'h1);
        step(); step();
        chk("t6_instr0", 32'(instr), 32'h41230);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
